// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial transmitter (and a future receiver).
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Number of bit periods in one frame: start + data + optional parity + stop.
   function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
      return 1 + data_w + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/bit_strobe_sync.sv
// Brings the divided bit clock into the clk domain and turns each rising edge
// into a single-cycle strobe. Edges seen while disabled are dropped.
module bit_strobe_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic bit_clk_i,
   input  logic enable_i,
   output logic bit_tick_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Two-flop synchroniser followed by a history flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= bit_clk_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // The history flop keeps tracking while disabled, so a rise during disable is lost.
   assign bit_tick_o = sync2_q & ~prev_q & enable_i;

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, optional
// even parity, one or two stop bits. A one-entry holding register lets the next
// word be queued so frames follow each other with no idle bit in between.
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY_EN = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              bit_clk,
   input  logic              enable,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              parity_q, parity_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic              tx_out_q, tx_out_d;
   logic              frame_done_q, frame_done_d;
   logic              load_frame;
   logic              bit_tick;

   bit_strobe_sync u_strobe (
      .clk        (clk),
      .reset_n    (reset_n),
      .bit_clk_i  (bit_clk),
      .enable_i   (enable),
      .bit_tick_o (bit_tick)
   );

   // Handshake capture and frame sequencing; the FSM only moves on bit_tick.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      parity_d     = parity_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      tx_out_d     = tx_out_q;
      frame_done_d = 1'b0;
      load_frame   = 1'b0;

      // No bypass: a word is only accepted into an empty holding register.
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (bit_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (hold_full_q) begin
                  load_frame = 1'b1;
               end
            end
            ST_START: begin
               state_d  = ST_DATA;
               tx_out_d = shift_q[0];
            end
            ST_DATA: begin
               if (int'(bit_cnt_q) < DATA_W - 1) begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_out_d  = shift_d[0];
               end else if (PARITY_EN != 0) begin
                  state_d  = ST_PARITY;
                  tx_out_d = parity_q;
               end else begin
                  state_d    = ST_STOP;
                  tx_out_d   = 1'b1;
                  stop_cnt_d = 1'b0;
               end
            end
            ST_PARITY: begin
               state_d    = ST_STOP;
               tx_out_d   = 1'b1;
               stop_cnt_d = 1'b0;
            end
            ST_STOP: begin
               if (STOP_BITS == 2 && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  frame_done_d = 1'b1;
                  if (hold_full_q) begin
                     load_frame = 1'b1;
                  end else begin
                     state_d  = ST_IDLE;
                     tx_out_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               tx_out_d = 1'b1;
            end
         endcase
      end

      // Moving the held word into the shifter also fixes its parity bit.
      if (load_frame) begin
         state_d     = ST_START;
         tx_out_d    = 1'b0;
         shift_d     = hold_q;
         parity_d    = ^hold_q;
         hold_full_d = 1'b0;
         bit_cnt_d   = '0;
      end
   end

   // State register; reset aborts any frame and drops the held word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         parity_q     <= 1'b0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         tx_out_q     <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         parity_q     <= parity_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         tx_out_q     <= tx_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx_ready   = ~hold_full_q;
   assign tx_out     = tx_out_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (8N1 and 8E2) share the bit clock,
// enable and reset. A frame-as-bit-list model predicts every output each cycle.
module tb_serial_frame_tx;
   import serial_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       bit_clk = 1'b0;
   logic       enable = 1'b1;
   logic [1:0] tx_valid_a = 2'b00;
   logic [7:0] tx_data_a [2];
   logic [1:0] rdy_o, tx_o, busy_o, done_o;

   int n_err = 0;
   int n_checks = 0;
   bit checking = 1'b0;

   int cfg_par[2]  = '{0, 1};
   int cfg_stop[2] = '{1, 2};

   // model state: a frame is a list of line levels, one per bit period
   logic       m_hold_full[2];
   logic [7:0] m_hold[2];
   logic       m_active[2];
   int         m_bits[2][16];
   int         m_len[2];
   int         m_pos[2];
   logic       m_tx[2];
   logic       m_busy[2];
   logic       m_done[2];
   logic [2:0] hist;
   logic       tick_m;

   serial_frame_tx #(.DATA_W(8), .STOP_BITS(1), .PARITY_EN(0)) u0 (
      .clk(clk), .reset_n(reset_n), .bit_clk(bit_clk), .enable(enable),
      .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]), .tx_ready(rdy_o[0]),
      .tx_out(tx_o[0]), .busy(busy_o[0]), .frame_done(done_o[0])
   );

   serial_frame_tx #(.DATA_W(8), .STOP_BITS(2), .PARITY_EN(1)) u1 (
      .clk(clk), .reset_n(reset_n), .bit_clk(bit_clk), .enable(enable),
      .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]), .tx_ready(rdy_o[1]),
      .tx_out(tx_o[1]), .busy(busy_o[1]), .frame_done(done_o[1])
   );

   always #5 clk = ~clk;

   // divider with div_value=3: bit_clk toggles every 4 clk, period 8
   initial begin
      forever begin
         repeat (4) @(posedge clk);
         #1 bit_clk = ~bit_clk;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int inst, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s inst%0d: got %0d required %0d at %0t", name, inst, act, exp, $time);
      end
   endtask

   // line levels of one frame: start, data LSB first, parity, stop bits
   function automatic void make_frame(input int par, input int stops, input logic [7:0] w,
                                      output int bits[16], output int len);
      for (int k = 0; k < 16; k++) bits[k] = 1;
      bits[0] = 0;
      len = 1;
      for (int k = 0; k < 8; k++) begin
         bits[len] = int'(w[k]);
         len++;
      end
      if (par != 0) begin
         bits[len] = int'(^w);
         len++;
      end
      len += stops;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_hold_full[i] = 1'b0;
         m_hold[i]      = 8'h00;
         m_active[i]    = 1'b0;
         m_len[i]       = 0;
         m_pos[i]       = 0;
         m_tx[i]        = 1'b1;
         m_busy[i]      = 1'b0;
         m_done[i]      = 1'b0;
      end
      hist = 3'b000;
   endtask

   task automatic model_step(input int i, input logic tick);
      logic cap;
      int   tmp[16];
      int   tl;
      cap = tx_valid_a[i] & ~m_hold_full[i];
      m_done[i] = 1'b0;
      if (tick) begin
         if (m_active[i] && m_pos[i] < m_len[i] - 1) begin
            m_pos[i]++;
            m_tx[i] = (m_bits[i][m_pos[i]] != 0);
         end else begin
            if (m_active[i]) m_done[i] = 1'b1;
            if (m_hold_full[i]) begin
               make_frame(cfg_par[i], cfg_stop[i], m_hold[i], tmp, tl);
               for (int k = 0; k < 16; k++) m_bits[i][k] = tmp[k];
               m_len[i]       = tl;
               m_pos[i]       = 0;
               m_tx[i]        = (tmp[0] != 0);
               m_active[i]    = 1'b1;
               m_hold_full[i] = 1'b0;
            end else begin
               m_active[i] = 1'b0;
               m_tx[i]     = 1'b1;
            end
         end
      end
      if (cap) begin
         m_hold_full[i] = 1'b1;
         m_hold[i]      = tx_data_a[i];
      end
      m_busy[i] = m_active[i];
   endtask

   // model advance: a bit_clk rise sampled two edges ago yields a tick now
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         tick_m = hist[1] & ~hist[2] & enable;
         for (int i = 0; i < 2; i++) model_step(i, tick_m);
         hist = {hist[1:0], bit_clk};
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            check("tx_out", i, int'(tx_o[i]), int'(m_tx[i]));
            check("busy", i, int'(busy_o[i]), int'(m_busy[i]));
            check("frame_done", i, int'(done_o[i]), int'(m_done[i]));
            check("tx_ready", i, int'(rdy_o[i]), int'(!m_hold_full[i]));
         end
      end
   end

   task automatic send(input int i, input logic [7:0] w);
      bit acc = 1'b0;
      logic r;
      tx_data_a[i]  = w;
      tx_valid_a[i] = 1'b1;
      for (int c = 0; c < 400 && !acc; c++) begin
         @(negedge clk);
         r = rdy_o[i];
         @(posedge clk);
         #1;
         if (r) acc = 1'b1;
      end
      tx_valid_a[i] = 1'b0;
      check("send_accept", i, int'(acc), 1);
   endtask

   task automatic wait_idle(input int i);
      bit ok = 1'b0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge clk);
         if (!busy_o[i] && rdy_o[i]) ok = 1'b1;
      end
      check("idle_wait", i, int'(ok), 1);
   endtask

   task automatic wait_fall(input int i, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (tx_o[i] == 1'b0) seen = 1'b1;
      end
      check("start_seen", i, int'(seen), 1);
   endtask

   // sample the line mid-bit for a whole frame and compare with a literal list
   task automatic frame_literal(input int i, input int seq[16], input int n, input string name);
      bit seen;
      wait_fall(i, seen);
      if (seen) begin
         repeat (3) @(negedge clk);
         check(name, i, int'(tx_o[i]), seq[0]);
         for (int b = 1; b < n; b++) begin
            repeat (8) @(negedge clk);
            check(name, i, int'(tx_o[i]), seq[b]);
         end
      end
   endtask

   int   seq_a5[16] = '{0,1,0,1,0,0,1,0,1,1,1,1,1,1,1,1};
   int   seq_07[16] = '{0,1,1,1,0,0,0,0,0,1,1,1,1,1,1,1};
   int   tmp_bits[16];
   int   tmp_len;
   bit   seen_m;
   bit   found;
   logic r0, r1;

   initial begin
      tx_data_a[0] = 8'h00;
      tx_data_a[1] = 8'h00;

      // model pinned by hand-derived frames
      make_frame(0, 1, 8'hA5, tmp_bits, tmp_len);
      check("model_len_8n1", 0, tmp_len, frame_len(8, 0, 1));
      for (int k = 0; k < 10; k++) check("model_a5", 0, tmp_bits[k], seq_a5[k]);
      make_frame(1, 2, 8'h07, tmp_bits, tmp_len);
      check("model_len_8e2", 1, tmp_len, 12);
      for (int k = 0; k < 12; k++) check("model_07", 1, tmp_bits[k], seq_07[k]);

      // reset with tx_valid asserted
      repeat (2) @(posedge clk);
      checking = 1'b1;
      #1;
      tx_valid_a   = 2'b11;
      tx_data_a[0] = 8'h3C;
      tx_data_a[1] = 8'hC3;
      repeat (4) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check("rst_tx_out", i, int'(tx_o[i]), 1);
            check("rst_ready", i, int'(rdy_o[i]), 1);
            check("rst_busy", i, int'(busy_o[i]), 0);
            check("rst_done", i, int'(done_o[i]), 0);
         end
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rel_tx_out", i, int'(tx_o[i]), 1);
         check("rel_ready", i, int'(rdy_o[i]), 1);
         check("rel_busy", i, int'(busy_o[i]), 0);
      end
      @(posedge clk);
      #1 tx_valid_a = 2'b00;
      wait_idle(0);
      wait_idle(1);

      // basic 8N1 frame and 8E2 frame
      send(0, 8'hA5);
      frame_literal(0, seq_a5, 10, "a5_bits");
      wait_idle(0);
      send(1, 8'h07);
      frame_literal(1, seq_07, 12, "p07_bits");
      wait_idle(1);

      // back-to-back: second word queued while the first is in DATA
      send(0, 8'h55);
      repeat (20) @(posedge clk);
      #1;
      send(0, 8'h0F);
      @(negedge clk);
      check("b2b_ready_low", 0, int'(rdy_o[0]), 0);
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (done_o[0]) found = 1'b1;
      end
      check("b2b_done_seen", 0, int'(found), 1);
      check("b2b_start", 0, int'(tx_o[0]), 0);
      check("b2b_busy", 0, int'(busy_o[0]), 1);
      check("b2b_ready_high", 0, int'(rdy_o[0]), 1);
      wait_idle(0);

      // enable freeze during data bit 3 of 0xA5 (a 0 bit)
      send(0, 8'hA5);
      wait_fall(0, seen_m);
      repeat (34) @(negedge clk);
      @(posedge clk);
      #1 enable = 1'b0;
      repeat (40) begin
         @(negedge clk);
         check("freeze_hold", 0, int'(tx_o[0]), 0);
      end
      @(posedge clk);
      #1 enable = 1'b1;
      wait_idle(0);

      // reset in the middle of DATA with a second word held
      send(0, 8'h00);
      repeat (20) @(posedge clk);
      #1;
      send(0, 8'hC3);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("mr_pre_tx", 0, int'(tx_o[0]), 0);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("mr_tx_out", 0, int'(tx_o[0]), 1);
      check("mr_ready", 0, int'(rdy_o[0]), 1);
      check("mr_busy", 0, int'(busy_o[0]), 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (60) begin
         @(negedge clk);
         check("mr_quiet", 0, int'(tx_o[0]), 1);
      end

      // randomized traffic and enable drops on both instances
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         r0 = rdy_o[0];
         r1 = rdy_o[1];
         @(posedge clk);
         #1;
         if (tx_valid_a[0] && r0) tx_valid_a[0] = 1'b0;
         if (tx_valid_a[1] && r1) tx_valid_a[1] = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (!tx_valid_a[i] && $urandom_range(0, 99) < 8) begin
               tx_valid_a[i] = 1'b1;
               tx_data_a[i]  = 8'($urandom);
            end
         end
         if (enable && $urandom_range(0, 999) < 5) enable = 1'b0;
         else if (!enable && $urandom_range(0, 99) < 4) enable = 1'b1;
      end
      @(negedge clk);
      r0 = rdy_o[0];
      r1 = rdy_o[1];
      @(posedge clk);
      #1;
      if (!r0) tx_valid_a[0] = 1'b0;
      if (!r1) tx_valid_a[1] = 1'b0;
      @(posedge clk);
      #1;
      tx_valid_a = 2'b00;
      enable = 1'b1;
      wait_idle(0);
      wait_idle(1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
